// File: rtl/and_gate_sync.sv
// and_gate_sync: bitwise AND with combinational and registered results,
// a per-bit rising-edge pulse and an optional input-pair coverage monitor.
//
// Parameters:
//   WIDTH  bit width of A, B, Y, Y_q, y_rise
//   CNT_W  width of each coverage counter
// Ports:
//   A, B        in   WIDTH  operands
//   Y           out  WIDTH  A & B, combinational
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous active-low reset
//   Y_q         out  WIDTH  A & B registered
//   y_rise      out  WIDTH  one-cycle pulse on each 0->1 of Y_q
//   cov_cnt_xx  out  CNT_W  saturating hit counts of {A[0],B[0]}
//   cov_all     out  1      all four counters non-zero
// Build option: define AND_GATE_SYNC_COV_EN to include the coverage
// monitor; otherwise the cov_* outputs are tied to zero.
module and_gate_sync #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] Y_q,
  output logic [WIDTH-1:0] y_rise,
  output logic [CNT_W-1:0] cov_cnt_00,
  output logic [CNT_W-1:0] cov_cnt_01,
  output logic [CNT_W-1:0] cov_cnt_10,
  output logic [CNT_W-1:0] cov_cnt_11,
  output logic             cov_all
);

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] r_y_q;
  logic [WIDTH-1:0] r_rise;

  assign w_and = A & B;
  assign Y     = w_and;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q  <= '0;
      r_rise <= '0;
    end else begin
      r_rise <= w_and & ~r_y_q;
      r_y_q  <= w_and;
    end
  end

  assign Y_q    = r_y_q;
  assign y_rise = r_rise;

`ifdef AND_GATE_SYNC_COV_EN

  logic [1:0]            r_pair;
  logic                  r_first;
  logic [3:0][CNT_W-1:0] r_cnt;
  logic                  r_all;

  logic [1:0]            w_pair;
  logic                  w_hit;
  logic [3:0][CNT_W-1:0] w_cnt_nxt;
  logic                  w_all_nxt;

  assign w_pair = {A[0], B[0]};
  // A held pair counts once; the first sample after reset always counts.
  assign w_hit  = r_first | (w_pair != r_pair);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_hit && (r_cnt[w_pair] != {CNT_W{1'b1}})) begin
      w_cnt_nxt[w_pair] = r_cnt[w_pair] + CNT_W'(1);
    end
    w_all_nxt = (|w_cnt_nxt[0]) & (|w_cnt_nxt[1])
              & (|w_cnt_nxt[2]) & (|w_cnt_nxt[3]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pair  <= 2'b00;
      r_first <= 1'b1;
      r_cnt   <= '0;
      r_all   <= 1'b0;
    end else begin
      r_pair  <= w_pair;
      r_first <= 1'b0;
      r_cnt   <= w_cnt_nxt;
      r_all   <= w_all_nxt;
    end
  end

  assign cov_cnt_00 = r_cnt[0];
  assign cov_cnt_01 = r_cnt[1];
  assign cov_cnt_10 = r_cnt[2];
  assign cov_cnt_11 = r_cnt[3];
  assign cov_all    = r_all;

`else

  assign cov_cnt_00 = '0;
  assign cov_cnt_01 = '0;
  assign cov_cnt_10 = '0;
  assign cov_cnt_11 = '0;
  assign cov_all    = 1'b0;

`endif

endmodule

// File: tb/tb_and_gate_sync.sv
// tb_and_gate_sync: directed and random checks of and_gate_sync
// against a behavioural model (WIDTH=8, CNT_W=2).
module tb_and_gate_sync;

`ifdef AND_GATE_SYNC_COV_EN
  localparam bit COV = 1'b1;
`else
  localparam bit COV = 1'b0;
`endif

  localparam int W  = 8;
  localparam int CW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [W-1:0]  Y, Y_q, y_rise;
  logic [CW-1:0] c00, c01, c10, c11;
  logic          cov_all;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_yq;
  logic [W-1:0] m_rise;
  int           m_cnt [4];
  int           m_last;
  bit           m_first;

  always #5 clk = ~clk;

  and_gate_sync #(.WIDTH(W), .CNT_W(CW)) dut (
    .A(A), .B(B), .Y(Y),
    .clk(clk), .rst_n(rst_n),
    .Y_q(Y_q), .y_rise(y_rise),
    .cov_cnt_00(c00), .cov_cnt_01(c01),
    .cov_cnt_10(c10), .cov_cnt_11(c11),
    .cov_all(cov_all)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ecnt(input int i);
    return COV ? 8'(m_cnt[i]) : 8'h00;
  endfunction

  function automatic logic [7:0] eall();
    bit all;
    all = (m_cnt[0] > 0) && (m_cnt[1] > 0) &&
          (m_cnt[2] > 0) && (m_cnt[3] > 0);
    return COV ? {7'd0, all} : 8'h00;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic r);
    int idx;
    if (!r) begin
      m_yq = '0;
      m_rise = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_last = 0;
      m_first = 1'b1;
    end else begin
      m_rise = (a & b) & ~m_yq;
      m_yq = a & b;
      idx = a[0] * 2 + b[0];
      if (m_first || idx != m_last) begin
        if (m_cnt[idx] < SAT) m_cnt[idx] = m_cnt[idx] + 1;
      end
      m_last = idx;
      m_first = 1'b0;
    end
  endtask

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic r, input string tag);
    A = a;
    B = b;
    rst_n = r;
    #1;
    chk({tag, ".Y"}, Y, a & b);
    @(posedge clk);
    model(a, b, r);
    #1;
    chk({tag, ".Y_q"}, Y_q, m_yq);
    chk({tag, ".y_rise"}, y_rise, m_rise);
    chk({tag, ".cnt00"}, {6'd0, c00}, ecnt(0));
    chk({tag, ".cnt01"}, {6'd0, c01}, ecnt(1));
    chk({tag, ".cnt10"}, {6'd0, c10}, ecnt(2));
    chk({tag, ".cnt11"}, {6'd0, c11}, ecnt(3));
    chk({tag, ".cov_all"}, {7'd0, cov_all}, eall());
  endtask

  initial begin
    // reset with both operands high: Y follows, registers stay clear
    step(8'hFF, 8'hFF, 1'b0, "rst0");
    step(8'hFF, 8'hFF, 1'b0, "rst1");
    chk("rst.Y_q_zero", Y_q, 8'h00);
    step(8'hFF, 8'hFF, 1'b1, "rel");
    chk("rel.Y_q_ff", Y_q, 8'hFF);

    // truth table
    step(8'h00, 8'h00, 1'b1, "tt00");
    step(8'h00, 8'hFF, 1'b1, "tt01");
    step(8'hFF, 8'h00, 1'b1, "tt10");
    step(8'hFF, 8'hFF, 1'b1, "tt11");

    // rise pulse: B 0->1 with A held, then B 1->0
    step(8'hFF, 8'h00, 1'b1, "rise0");
    step(8'hFF, 8'hFF, 1'b1, "rise1");
    chk("rise.pulse", y_rise, 8'hFF);
    step(8'hFF, 8'hFF, 1'b1, "rise2");
    chk("rise.once", y_rise, 8'h00);
    step(8'hFF, 8'h00, 1'b1, "fall");

    // coverage: each pair once, three cycles each, from reset
    step(8'h00, 8'h00, 1'b0, "cvrst");
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 3; k++) begin
        step({7'd0, p[1]}, {7'd0, p[0]}, 1'b1, "cov");
      end
    end
    chk("cov.all_dir", {7'd0, cov_all}, {7'd0, COV});
    chk("cov.c11_dir", {6'd0, c11}, {7'd0, COV});

    // saturation: 00<->11 ten toggles
    step(8'h00, 8'h00, 1'b0, "satrst");
    for (int k = 0; k < 10; k++) begin
      step(8'h00, 8'h00, 1'b1, "sat00");
      step(8'h01, 8'h01, 1'b1, "sat11");
    end
    chk("sat.c00_dir", {6'd0, c00}, COV ? 8'd3 : 8'd0);

    // wide operand
    step(8'hF0, 8'h3C, 1'b1, "wide");
    chk("wide.Y_q", Y_q, 8'h30);

    // random traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      step(W'($urandom), W'($urandom),
           ($urandom_range(0, 15) != 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/and_gate_sync.md
# and_gate_sync

Bitwise two-input AND primitive for the gate-level library. It provides the combinational result plus a registered copy, a rising-edge pulse and an optional input-combination coverage monitor. It sits at the leaf level: instantiated directly by gate-level datapaths and gate-exercise benches.

## Interface
- WIDTH, 1, bit width of A, B, Y, Y_q.
- CNT_W, 8, width of each coverage counter (coverage build only).

Ports, in bullet order below; RTL declaration order is A, B, Y, clk, rst_n, then the rest, so a 3-port positional hookup (A, B, Y) stays valid:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Y  output  WIDTH  combinational A & B.
- Y_q  output  WIDTH  registered A & B.
- y_rise  output  WIDTH  one-cycle pulse per bit where Y_q goes 0->1.
- cov_cnt_00/01/10/11  output  CNT_W each  hits of {A[0],B[0]} = 00/01/10/11 (coverage build only).
- cov_all  output  1  all four coverage counters non-zero (coverage build only).

## Operation
- Y = A & B, bitwise, purely combinational; valid regardless of clk/rst_n.
- Y_q <= A & B every rising edge when rst_n = 1.
- y_rise <= (A & B) & ~Y_q every edge (registered; high for exactly one cycle per 0->1 transition of Y_q).
- Coverage: internal register pair_q holds last sampled {A[0],B[0]} plus a first_q flag set by reset.
- A counter increments when current pair differs from pair_q, or when first_q = 1 (first post-reset sample); first_q then clears.
- Counters saturate at 2^CNT_W-1; no wrap.
- Static input held many cycles counts once.
- X/Z on A or B: Y follows standard Verilog & semantics (0 & X = 0); no extra handling.

## Timing
- Y: zero-cycle latency.
- Y_q, y_rise, counters, cov_all: one-cycle latency, all updated on the same edge.
- Reset (rst_n = 0 sampled at edge): Y_q = 0, y_rise = 0, all counters = 0, cov_all = 0, pair_q = 0, first_q = 1. Y unaffected.
- Reset mid-operation: registers clear on that edge; first sample after deassertion counts regardless of prior pair.
- Reset dominates any simultaneous input change.
- cov_all is registered from the counter values after update (rises the same edge the fourth counter becomes non-zero).

## Configuration
- Macro AND_GATE_SYNC_COV_EN.
- Defined: pair_q, first_q, four saturating counters and cov_all present as described.
- Not defined: coverage logic absent; cov_* ports remain but are tied to 0; Y, Y_q, y_rise unchanged.

## Test plan
- Truth table, WIDTH=1, rst_n=1: A,B = 00,01,10,11 each held 10 ns -> Y = 0,0,0,1 immediately; Y_q equals Y one edge later.
- Rise pulse: A=1 held, B 0->1 -> y_rise = 1 for exactly one cycle, Y_q = 1 thereafter; B 1->0 -> y_rise stays 0.
- Reset: drive A=B=1, assert rst_n=0 for 2 edges -> Y = 1, Y_q = 0, y_rise = 0, counters 0; release -> Y_q = 1 next edge.
- Coverage (macro on): apply 00,01,10,11 once each, 3 cycles each -> every counter = 1, cov_all = 1 after the 11 sample edge; macro off -> all cov_* = 0.
- Saturation (CNT_W=2): toggle pair 00<->11 ten times -> cov_cnt_00 = cov_cnt_11 = 3, no wrap.
- WIDTH=8: A=8'hF0, B=8'h3C -> Y = 8'h30; Y_q = 8'h30 next edge.
